// File: rtl/codebreak_pkg.sv
// Shared CodeBreak types: digit width, FSM states and the fallback code builder.
package codebreak_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned MAX_DIGS = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // Fallback code: digit i holds the value i (0x3210 for four digits).
  function automatic logic [MAX_DIGS*DIGIT_W-1:0] fallback_code(input int unsigned num_digits);
    logic [MAX_DIGS*DIGIT_W-1:0] f;
    f = '0;
    for (int unsigned i = 0; i < MAX_DIGS; i++) begin
      if (i < num_digits) f[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(i);
    end
    return f;
  endfunction

endpackage

// File: rtl/code_digit_check.sv
// Folds raw nibbles into decimal-range digits and flags any repeated digit.
module code_digit_check
  import codebreak_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_BASE = 10
) (
  input  logic [DIGIT_W*NUM_DIGITS-1:0] i_nibbles,
  output logic [DIGIT_W*NUM_DIGITS-1:0] o_digits,
  output logic                          o_dup
);

  localparam logic [DIGIT_W:0] BASE_W = (DIGIT_W+1)'(DIGIT_BASE);

  digit_t w_digit [NUM_DIGITS];

  // Fold each nibble by subtracting the base at most twice (second pass only matters for tiny bases).
  always_comb begin
    logic [DIGIT_W:0] w_val;
    w_val    = '0;
    o_digits = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_val = {1'b0, i_nibbles[i*DIGIT_W +: DIGIT_W]};
      if (w_val >= BASE_W) w_val = w_val - BASE_W;
      if (w_val >= BASE_W) w_val = w_val - BASE_W;
      w_digit[i] = w_val[DIGIT_W-1:0];
      o_digits[i*DIGIT_W +: DIGIT_W] = w_val[DIGIT_W-1:0];
    end
  end

  // Pairwise compare of folded digits.
  always_comb begin
    o_dup = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      for (int unsigned j = i + 1; j < NUM_DIGITS; j++) begin
        if (w_digit[i] == w_digit[j]) o_dup = 1'b1;
      end
    end
  end

endmodule

// File: rtl/secret_code_gen.sv
// Draws random codes, rejects repeated digits with bounded retries and latches the secret code.
module secret_code_gen
  import codebreak_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIGIT_BASE  = 10,
  parameter int unsigned DISTINCT    = 1,
  parameter int unsigned MAX_RETRIES = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          rand_req,
  input  logic [15:0]                   rand_in,
  output logic [DIGIT_W*NUM_DIGITS-1:0] code,
  output logic                          code_valid,
  output logic                          busy,
  output logic                          fallback,
  output logic [3:0]                    retries
);

  localparam int unsigned CODE_W = DIGIT_W * NUM_DIGITS;

  state_t                      r_state;
  logic [CODE_W-1:0]           r_code;
  logic                        r_code_valid;
  logic                        r_rand_req;
  logic                        r_busy;
  logic                        r_fallback;
  logic [3:0]                  r_retries;

  logic [CODE_W-1:0]           w_digits;
  logic                        w_dup;
  logic [MAX_DIGS*DIGIT_W-1:0] w_fb_full;
  logic [CODE_W-1:0]           w_fb;

  assign w_fb_full = fallback_code(NUM_DIGITS);
  assign w_fb      = w_fb_full[CODE_W-1:0];

  code_digit_check #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_BASE (DIGIT_BASE)
  ) u_check (
    .i_nibbles (rand_in[CODE_W-1:0]),
    .o_digits  (w_digits),
    .o_dup     (w_dup)
  );

  // Control FSM; all outputs are registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_rand_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_fallback   <= 1'b0;
      r_retries    <= 4'd0;
    end else begin
      r_rand_req <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state      <= REQ;
            r_rand_req   <= 1'b1;
            r_busy       <= 1'b1;
            r_code_valid <= 1'b0;
            r_fallback   <= 1'b0;
            r_retries    <= 4'd0;
          end
        end
        REQ:  r_state <= WAIT;
        WAIT: r_state <= CHECK;
        CHECK: begin
          if ((DISTINCT == 0) || !w_dup) begin
            r_code       <= w_digits;
            r_code_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= DONE;
          end else if (r_retries < 4'(MAX_RETRIES)) begin
            r_retries  <= r_retries + 4'd1;
            r_rand_req <= 1'b1;
            r_state    <= REQ;
          end else begin
            r_code       <= w_fb;
            r_fallback   <= 1'b1;
            r_code_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rand_req   = r_rand_req;
  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign busy       = r_busy;
  assign fallback   = r_fallback;
  assign retries    = r_retries;

endmodule

// File: tb/tb_secret_code_gen.sv
// Randomized bench for secret_code_gen against a draw-sequence reference model.
module tb_secret_code_gen;

  typedef logic [15:0] draw_q_t [$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rand_req;
  logic [15:0] rand_in = 16'h0000;
  logic [15:0] code;
  logic        code_valid;
  logic        busy;
  logic        fallback;
  logic [3:0]  retries;

  logic        start_nd;
  logic        rand_req_nd;
  logic [15:0] rand_in_nd;
  logic [15:0] code_nd;
  logic        code_valid_nd;
  logic        busy_nd;
  logic        fallback_nd;
  logic [3:0]  retries_nd;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  draw_q_t src_q;

  always #5 clk = ~clk;

  secret_code_gen u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rand_req   (rand_req),
    .rand_in    (rand_in),
    .code       (code),
    .code_valid (code_valid),
    .busy       (busy),
    .fallback   (fallback),
    .retries    (retries)
  );

  secret_code_gen #(.DISTINCT(0)) u_dut_nd (
    .clk        (clk),
    .rst        (rst),
    .start      (start_nd),
    .rand_req   (rand_req_nd),
    .rand_in    (rand_in_nd),
    .code       (code_nd),
    .code_valid (code_valid_nd),
    .busy       (busy_nd),
    .fallback   (fallback_nd),
    .retries    (retries_nd)
  );

  // Random source: each rand_req pulse presents the next queued draw; an empty queue holds the last one.
  always @(posedge clk) begin
    if (rand_req) begin
      pulses++;
      if (src_q.size() > 0) rand_in <= src_q.pop_front();
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  // Reference: walk the presented draws, map nibbles into base 10, accept the first distinct code.
  function automatic void model(input draw_q_t q, output logic [15:0] e_code, output int e_ret,
                                output int e_fb, output int e_lat, output int e_pulses);
    e_code = 16'h3210; e_ret = 15; e_fb = 1; e_lat = 4 + 3 * 15; e_pulses = 16;
    for (int k = 0; k <= 15; k++) begin
      logic [15:0] r;
      int d [4];
      bit seen [16];
      bit rep;
      r   = q[(k < q.size()) ? k : q.size() - 1];
      rep = 0;
      foreach (seen[s]) seen[s] = 0;
      for (int i = 0; i < 4; i++) begin
        d[i] = (r >> (4 * i)) & 15;
        if (d[i] >= 10) d[i] = d[i] - 10;
        if (seen[d[i]]) rep = 1;
        seen[d[i]] = 1;
      end
      if (!rep) begin
        e_code   = 16'(d[0] + 16 * d[1] + 256 * d[2] + 4096 * d[3]);
        e_ret    = k;
        e_fb     = 0;
        e_lat    = 4 + 3 * k;
        e_pulses = k + 1;
        return;
      end
    end
  endfunction

  // One full request using the draws currently in src_q; k counts negedges after the start edge.
  task automatic run_txn(input string tag);
    logic [15:0] e_code;
    int e_ret, e_fb, e_lat, e_pulses, k, base;
    model(src_q, e_code, e_ret, e_fb, e_lat, e_pulses);
    @(negedge clk);
    start = 1'b1;
    base  = pulses;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    chk({tag, "_rand_req_first"}, 32'(rand_req), 32'd1);
    while (!code_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(e_lat));
    chk({tag, "_code"}, 32'(code), 32'(e_code));
    chk({tag, "_retries"}, 32'(retries), 32'(e_ret));
    chk({tag, "_fallback"}, 32'(fallback), 32'(e_fb));
    chk({tag, "_pulses"}, 32'(pulses - base), 32'(e_pulses));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, base;
    rst = 1'b1; start = 1'b0; start_nd = 1'b0; rand_in_nd = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_rand_req", 32'(rand_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fallback", 32'(fallback), 32'd0);
    chk("rst_retries", 32'(retries), 32'd0);
    rst = 1'b0;

    src_q = {16'h1234};             run_txn("clean");
    src_q = {16'hFC39};             run_txn("fold");
    src_q = {16'hA1B2, 16'h9876};   run_txn("retry");
    src_q = {16'h1111};             run_txn("exhaust");
    src_q = {16'h0987};             run_txn("after_fallback");

    // Reset while waiting for the draw to settle.
    src_q = {16'h2468};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_rand_req", 32'(rand_req), 32'd0);
    chk("midrst_code", 32'(code), 32'd0);
    chk("midrst_valid", 32'(code_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_retries", 32'(retries), 32'd0);

    // start pulsed while in CHECK must be dropped.
    src_q = {16'h4567};
    @(negedge clk); start = 1'b1; base = pulses;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("ignore_valid", 32'(code_valid), 32'd1);
    chk("ignore_code", 32'(code), 32'h4567);
    @(negedge clk);
    chk("ignore_hold_valid", 32'(code_valid), 32'd1);
    chk("ignore_busy", 32'(busy), 32'd0);
    chk("ignore_pulses", 32'(pulses - base), 32'd1);

    // Repeated digits accepted when distinctness is disabled.
    rand_in_nd = 16'h7777;
    @(negedge clk); start_nd = 1'b1;
    @(negedge clk); start_nd = 1'b0;
    k = 1;
    while (!code_valid_nd && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("nd_latency", 32'(k), 32'd4);
    chk("nd_code", 32'(code_nd), 32'h7777);
    chk("nd_fallback", 32'(fallback_nd), 32'd0);
    chk("nd_retries", 32'(retries_nd), 32'd0);

    // Random draw sequences; the queue's last value repeats if it runs out.
    for (int t = 0; t < 25; t++) begin
      int nq;
      nq = int'($urandom_range(1, 4));
      src_q.delete();
      for (int i = 0; i < nq; i++) src_q.push_back(16'($urandom()));
      run_txn($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
